ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte to the keyboard, for example 0xED (set LEDs) or 0xFF (reset).
- Sits beside the keyboard receive register on the same open-drain PS/2 clock/data lines.
- Handles the full host request sequence: clock inhibit, start bit, 8 data bits LSB-first, odd parity, stop bit, then checks the device acknowledge bit.
- Raises busy so the receive path ignores line activity while a transmit is in progress.

Parameters:
- INHIBIT_CYCLES, 5000: sysClock cycles that ps2 clock is held low before the start bit (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000: maximum sysClock cycles allowed between consecutive device clock falling edges (15 ms at 50 MHz).
- TIMER_W, 20: width of the internal cycle timer. Must hold max(INHIBIT_CYCLES, TIMEOUT_CYCLES).

Ports:
- sysClock  in  1  system clock; all logic on its rising edge.
- sysResetN  in  1  asynchronous, active-low reset.
- txData  in  8  byte to send; captured when txValid && txReady.
- txValid  in  1  request strobe.
- txReady  out  1  high only in IDLE.
- ps2ClkIn  in  1  raw PS/2 clock line (asynchronous).
- ps2DataIn  in  1  raw PS/2 data line (asynchronous).
- ps2ClkDriveLow  out  1  1 = pull PS/2 clock low; 0 = release.
- ps2DataDriveLow  out  1  1 = pull PS/2 data low; 0 = release.
- busy  out  1  high in every state except IDLE.
- txDone  out  1  one-cycle pulse: byte sent and ack received.
- txError  out  1  one-cycle pulse: missing ack or timeout.

Behaviour:
- Reset (asynchronous, while sysResetN=0):
  - All outputs are 0 except txReady, which is 1.
  - State is IDLE; the timer and bit counter are cleared.
  - Both lines are released immediately, even mid-transfer. No error pulse is generated.
- Line sampling:
  - ps2ClkIn and ps2DataIn each pass through a 2-flop synchronizer.
  - A falling edge (fall) is sampled clock previous=1 and current=0. Fall is seen 3 sysClock cycles after the line transition.
- Frame: 11-bit frame = start(0), d0..d7, parity, stop(1). Parity is odd: the inverse of the XOR of txData.
- IDLE: txReady=1. On txValid, latch txData into a 10-bit shift register {1, parity, d7..d0} and go to INHIBIT.
- INHIBIT:
  - ps2ClkDriveLow=1 for INHIBIT_CYCLES.
  - On the final cycle also set ps2DataDriveLow=1 (start bit).
  - Then go to REQ.
- REQ:
  - Clock released, data held low.
  - On fall, drive shift register bit 0 (d0) and go to SEND with bitCount=1.
- SEND:
  - On each fall, shift and drive the next bit. ps2DataDriveLow = ~bit.
  - Falls 1..8 drive d0..d7, fall 9 drives parity, fall 10 releases data (stop).
  - After fall 10, go to ACK.
- ACK: on fall 11, sample synchronized data.
  - Data 0: go to WAIT_IDLE.
  - Data 1: pulse txError and go to IDLE.
- WAIT_IDLE: wait until synchronized clock=1 and data=1, then pulse txDone and go to IDLE.
  - WAIT_IDLE is subject to the same timeout as REQ/SEND/ACK.
- Timeout:
  - In REQ, SEND, ACK and WAIT_IDLE the timer clears on every fall and otherwise increments.
  - When it reaches TIMEOUT_CYCLES: release both lines, pulse txError, go to IDLE.
- txValid while busy is ignored; the request is not queued.
- txDone and txError are never asserted in the same cycle.
- The lines are never both released and driven in the same cycle. Drive signals are registered (no glitches).
- Minimum total latency, txValid to txDone: INHIBIT_CYCLES + 11 device clock periods + synchronizer delay.

Test Plan:
- Send 0xED with a compliant device model (10 kHz clock, ack=0).
  - Required: clock held low 5000 cycles, start 0, data bits 1,0,1,1,0,1,1,1, parity 1, stop released.
  - Required: txDone pulses once and txError stays 0.
- Send 0x00 (parity 1) and 0xFF (parity 1), then 0x01 (parity 0).
  - Required: the device model decodes each byte correctly and reports no parity error.
- Device holds data high at ack (fall 11).
  - Required: txError pulses for 1 cycle, txDone stays 0, state returns to IDLE with txReady=1.
- Device never clocks after the start bit.
  - Required: txError exactly TIMEOUT_CYCLES after entering REQ, and both drive outputs 0.
- Assert sysResetN=0 after fall 5.
  - Required: ps2ClkDriveLow=0, ps2DataDriveLow=0 and txReady=1 immediately, with no txDone or txError.
  - Required: the next send of 0xFF completes normally.
- Pulse txValid with 0xAA during a 0xED transfer.
  - Required: it is ignored and only 0xED appears on the line.

Source files
------------

// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
// PS/2 host-to-device command transmitter: inhibit, request-to-send,
// 10 clocked bits and acknowledge check on shared open-drain lines.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000,
    parameter int unsigned TIMER_W        = 20
) (
    input  logic       sysClock,
    input  logic       sysResetN,
    input  logic [7:0] txData,
    input  logic       txValid,
    output logic       txReady,
    input  logic       ps2ClkIn,
    input  logic       ps2DataIn,
    output logic       ps2ClkDriveLow,
    output logic       ps2DataDriveLow,
    output logic       busy,
    output logic       txDone,
    output logic       txError
);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAIT_IDLE
    } state_e;

    localparam logic [TIMER_W-1:0] INH_LAST = TIMER_W'(INHIBIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] INH_PRE  = TIMER_W'(INHIBIT_CYCLES - 2);
    localparam logic [TIMER_W-1:0] TMO_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic               INH_ONE  = (INHIBIT_CYCLES == 1);

    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [9:0]         shreg_q, shreg_d;
    logic [1:0]         clk_sync_q, clk_sync_d;
    logic [1:0]         data_sync_q, data_sync_d;
    logic               clk_prev_q, clk_prev_d;
    logic               clk_drv_q, clk_drv_d;
    logic               data_drv_q, data_drv_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic clk_s;
    logic data_s;
    logic fall;
    logic timeout;

    assign clk_s   = clk_sync_q[1];
    assign data_s  = data_sync_q[1];
    assign fall    = clk_prev_q & ~clk_s;
    assign timeout = (timer_q == TMO_LAST);

    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2ClkIn};
        data_sync_d = {data_sync_q[0], ps2DataIn};
        clk_prev_d  = clk_s;
        state_d     = state_q;
        timer_d     = timer_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        clk_drv_d   = clk_drv_q;
        data_drv_d  = data_drv_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        // Device-clocked states share one watchdog restarted by every fall
        if (fall) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                if (txValid) begin
                    shreg_d    = {1'b1, ~^txData, txData};
                    bit_cnt_d  = '0;
                    clk_drv_d  = 1'b1;
                    data_drv_d = INH_ONE;
                    state_d    = INHIBIT;
                end
            end
            INHIBIT: begin
                timer_d = timer_q + 1'b1;
                if (timer_q == INH_PRE) begin
                    data_drv_d = 1'b1;
                end
                if (timer_q == INH_LAST) begin
                    timer_d    = '0;
                    clk_drv_d  = 1'b0;
                    data_drv_d = 1'b1;
                    state_d    = REQ;
                end
            end
            REQ, SEND: begin
                if (fall) begin
                    data_drv_d = ~shreg_q[0];
                    shreg_d    = {1'b1, shreg_q[9:1]};
                    if (state_q == REQ) begin
                        bit_cnt_d = 4'd1;
                        state_d   = SEND;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd9) begin
                            state_d = ACK;
                        end
                    end
                end else if (timeout) begin
                    clk_drv_d  = 1'b0;
                    data_drv_d = 1'b0;
                    err_d      = 1'b1;
                    state_d    = IDLE;
                end
            end
            ACK: begin
                if (fall) begin
                    if (data_s) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_IDLE;
                    end
                end else if (timeout) begin
                    clk_drv_d  = 1'b0;
                    data_drv_d = 1'b0;
                    err_d      = 1'b1;
                    state_d    = IDLE;
                end
            end
            WAIT_IDLE: begin
                if (clk_s && data_s) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (!fall && timeout) begin
                    clk_drv_d  = 1'b0;
                    data_drv_d = 1'b0;
                    err_d      = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                clk_drv_d  = 1'b0;
                data_drv_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    // Synchronizers reset high so the idle bus never looks like a fall
    always_ff @(posedge sysClock or negedge sysResetN) begin
        if (!sysResetN) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
            clk_drv_q   <= 1'b0;
            data_drv_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
            clk_drv_q   <= clk_drv_d;
            data_drv_q  <= data_drv_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign ps2ClkDriveLow  = clk_drv_q;
    assign ps2DataDriveLow = data_drv_q;
    assign txReady         = (state_q == IDLE);
    assign busy            = (state_q != IDLE);
    assign txDone          = done_q;
    assign txError         = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
// Bench for ps2_host_tx: open-drain bus with a behavioural keyboard that
// decodes each host frame and checks it against queued expectations.
module tb_ps2_host_tx;

    localparam int INH = 50;
    localparam int TMO = 600;
    localparam int H   = 30;

    logic       sysClock  = 1'b0;
    logic       sysResetN = 1'b0;
    logic [7:0] txData    = 8'h00;
    logic       txValid   = 1'b0;
    logic       txReady;
    logic       ps2ClkDriveLow;
    logic       ps2DataDriveLow;
    logic       busy;
    logic       txDone;
    logic       txError;
    logic       dev_clk   = 1'b1;
    logic       dev_data  = 1'b1;
    logic       clk_line;
    logic       data_line;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       nack;
        int         exp_done;
        int         exp_err;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[5];

    assign clk_line  = dev_clk & ~ps2ClkDriveLow;
    assign data_line = dev_data & ~ps2DataDriveLow;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .TIMER_W(10)
    ) dut (
        .sysClock(sysClock),
        .sysResetN(sysResetN),
        .txData(txData),
        .txValid(txValid),
        .txReady(txReady),
        .ps2ClkIn(clk_line),
        .ps2DataIn(data_line),
        .ps2ClkDriveLow(ps2ClkDriveLow),
        .ps2DataDriveLow(ps2DataDriveLow),
        .busy(busy),
        .txDone(txDone),
        .txError(txError)
    );

    always #5 sysClock = ~sysClock;

    always @(negedge sysClock) begin
        if (txDone) done_cnt <= done_cnt + 1;
        if (txError) err_cnt <= err_cnt + 1;
        if (txDone && txError) both_cnt <= both_cnt + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic device(input logic nack);
        int n;
        int dn;
        logic [9:0] bits;
        exp_t e;
        n = 0;
        while (!ps2ClkDriveLow && n < 100) begin
            @(negedge sysClock);
            n++;
        end
        chk("inhibit_start", ps2ClkDriveLow, 1);
        n  = 0;
        dn = 0;
        while (ps2ClkDriveLow && n < 10 * INH) begin
            if (ps2DataDriveLow) dn++;
            n++;
            @(negedge sysClock);
        end
        chk("inhibit_len", n, INH);
        chk("start_overlap", dn, 1);
        chk("start_bit", ps2DataDriveLow, 1);
        chk("busy_tx", {busy, txReady}, 2'b10);
        repeat (10) @(negedge sysClock);
        for (int i = 0; i < 10; i++) begin
            dev_clk = 1'b0;
            repeat (H) @(negedge sysClock);
            bits[i] = data_line;
            dev_clk = 1'b1;
            repeat (H) @(negedge sysClock);
        end
        dev_data = nack;
        repeat (5) @(negedge sysClock);
        dev_clk = 1'b0;
        repeat (H) @(negedge sysClock);
        dev_clk = 1'b1;
        repeat (H) @(negedge sysClock);
        dev_data = 1'b1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            chk("data", bits[7:0], e.data);
            chk("parity_bit", bits[8], e.par);
            chk("parity_odd", ^bits[8:0], 1);
            chk("stop", bits[9], 1);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int d0;
        int e0;
        int n;
        d0 = done_cnt;
        e0 = err_cnt;
        sb_q.push_back('{data: v.data, par: v.par});
        @(negedge sysClock);
        txData  = v.data;
        txValid = 1'b1;
        @(negedge sysClock);
        txValid = 1'b0;
        device(v.nack);
        n = 0;
        while (!txReady && n < 500) begin
            @(negedge sysClock);
            n++;
        end
        chk("ready_wait", txReady, 1);
        repeat (5) @(negedge sysClock);
        chk("done_pulses", done_cnt - d0, v.exp_done);
        chk("err_pulses", err_cnt - e0, v.exp_err);
        chk("idle_drive", {ps2ClkDriveLow, ps2DataDriveLow, busy}, 3'b000);
    endtask

    initial begin
        int n;
        int d0;
        int e0;
        vecs[0] = '{8'hED, 1'b1, 1'b0, 1, 0};
        vecs[1] = '{8'h00, 1'b1, 1'b0, 1, 0};
        vecs[2] = '{8'hFF, 1'b1, 1'b0, 1, 0};
        vecs[3] = '{8'h01, 1'b0, 1'b0, 1, 0};
        vecs[4] = '{8'hED, 1'b1, 1'b1, 0, 1};

        repeat (3) @(negedge sysClock);
        chk("reset_out",
            {txReady, busy, ps2ClkDriveLow, ps2DataDriveLow, txDone, txError},
            6'b100000);
        sysResetN = 1'b1;
        repeat (3) @(negedge sysClock);

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
        end

        // No device clock after the start bit
        d0 = done_cnt;
        @(negedge sysClock);
        txData  = 8'h3C;
        txValid = 1'b1;
        @(negedge sysClock);
        txValid = 1'b0;
        n = 0;
        while (ps2ClkDriveLow && n < 10 * INH) begin
            @(negedge sysClock);
            n++;
        end
        n = 0;
        while (!txError && n < 2 * TMO) begin
            @(negedge sysClock);
            n++;
        end
        chk("timeout_cycles", n, TMO);
        chk("timeout_drive", {ps2ClkDriveLow, ps2DataDriveLow, txReady}, 3'b001);
        repeat (3) @(negedge sysClock);
        chk("timeout_no_done", done_cnt - d0, 0);

        // Reset while the host drives d4 of 0x00 low
        @(negedge sysClock);
        txData  = 8'h00;
        txValid = 1'b1;
        @(negedge sysClock);
        txValid = 1'b0;
        n = 0;
        while (!ps2ClkDriveLow && n < 10) begin
            @(negedge sysClock);
            n++;
        end
        n = 0;
        while (ps2ClkDriveLow && n < 10 * INH) begin
            @(negedge sysClock);
            n++;
        end
        repeat (10) @(negedge sysClock);
        for (int i = 0; i < 4; i++) begin
            dev_clk = 1'b0;
            repeat (H) @(negedge sysClock);
            dev_clk = 1'b1;
            repeat (H) @(negedge sysClock);
        end
        dev_clk = 1'b0;
        repeat (10) @(negedge sysClock);
        chk("mid_drive", {busy, ps2DataDriveLow}, 2'b11);
        d0 = done_cnt;
        e0 = err_cnt;
        #2;
        sysResetN = 1'b0;
        #1;
        chk("rst_async",
            {ps2ClkDriveLow, ps2DataDriveLow, txReady, busy}, 4'b0010);
        dev_clk = 1'b1;
        repeat (3) @(negedge sysClock);
        sysResetN = 1'b1;
        repeat (5) @(negedge sysClock);
        chk("rst_no_pulse", {done_cnt - d0, err_cnt - e0}, 0);
        run_vec('{8'hFF, 1'b1, 1'b0, 1, 0});

        // Second request while busy must be dropped
        fork
            run_vec(vecs[0]);
            begin
                repeat (300) @(negedge sysClock);
                txData  = 8'hAA;
                txValid = 1'b1;
                @(negedge sysClock);
                txValid = 1'b0;
            end
        join
        n = 0;
        repeat (100) begin
            @(negedge sysClock);
            if (ps2ClkDriveLow || busy) n++;
        end
        chk("no_requeue", n, 0);
        chk("sb_drained", sb_q.size(), 0);
        chk("done_err_overlap", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
